// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write-side logic.
package fifo_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
   localparam int DATA_SIZE_DEF = 8;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority selector: picks the first set req bit at or above ptr, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      idx
);
   int best;
   int d;

   // Distance from ptr going upward modulo NUM_REQ; the smallest distance wins.
   always_comb begin
      found = |req;
      idx   = '0;
      best  = NUM_REQ;
      d     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         d = (i >= int'(ptr)) ? i - int'(ptr) : i + NUM_REQ - int'(ptr);
         if (req[i] && d < best) begin
            best = d;
            idx  = IW'(i);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                         w_clk,
   input  logic                         w_rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
   input  logic                         full,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         w_en,
   output logic [DATA_SIZE-1:0]         w_data,
   output logic [$clog2(NUM_REQ)-1:0]   owner,
   output logic                         busy
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_LEN + 1);

   state_t                 state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   busy_q;
   logic                   found;
   logic [IW-1:0]          pick;
   logic [IW-1:0]          nxt;
   logic                   own_req;
   logic                   wr;
   logic [DATA_SIZE-1:0]   own_data;

   rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (found),
      .idx   (pick)
   );

   // Write path is combinational so full blocks the write in the same cycle.
   always_comb begin
      own_req  = 1'b0;
      own_data = '0;
      grant    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IW'(i)) begin
            own_req  = req[i];
            own_data = req_data[i*DATA_SIZE +: DATA_SIZE];
         end
      end
      wr     = (state_q == ST_BURST) && own_req && !full;
      w_en   = wr;
      w_data = wr ? own_data : '0;
      for (int i = 0; i < NUM_REQ; i++) grant[i] = wr && (owner_q == IW'(i));
      nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               owner_d = pick;
               cnt_d   = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            // A dropped request ends the burst even when full is also high.
            if (!own_req) begin
               state_d = ST_IDLE;
               ptr_d   = nxt;
            end else if (!full) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(BURST_LEN - 1)) begin
                  state_d = ST_IDLE;
                  ptr_d   = nxt;
               end
            end
         end
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == ST_BURST);
      end
   end

   assign owner = owner_q;
   assign busy  = busy_q;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the dual-clock FIFO among NUM_REQ producers in the write clock domain. It grants one producer at a time for bursts of up to BURST_LEN words and drives the FIFO's w_en/w_data directly. It stalls cleanly on full and sits between the producer logic and the FIFO write interface.

## Interface
Parameters:
- DATA_SIZE, 8, word width; matches the FIFO DATA_SIZE.
- NUM_REQ, 4, number of producers; 2..16.
- BURST_LEN, 4, maximum words per grant; 1..256.

Ports:
- w_clk  input  1  write-domain clock; the block's only clock.
- w_rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-producer request; held high while the producer has a word on req_data.
- req_data  input  NUM_REQ*DATA_SIZE  producer words; producer i uses bits [i*DATA_SIZE +: DATA_SIZE].
- full  input  1  FIFO full flag, write domain.
- grant  output  NUM_REQ  one-hot; bit i high means producer i's current word is written this cycle.
- w_en  output  1  FIFO write enable.
- w_data  output  DATA_SIZE  FIFO write data.
- owner  output  $clog2(NUM_REQ)  index of the current or last burst owner.
- busy  output  1  high in the BURST state.

## Operation
- There are two states, IDLE and BURST.
- Registered state:
  - state
  - owner
  - ptr (next-priority index)
  - cnt (words written in the current burst, width $clog2(BURST_LEN+1))
- IDLE:
  - If req is nonzero, select the first set bit at or above ptr, wrapping modulo NUM_REQ.
  - Load that index into owner, clear cnt, go to BURST.
  - Nothing is written in IDLE.
- BURST, per cycle:
  - If !req[owner]: go to IDLE. Set ptr = (owner+1) mod NUM_REQ. No write.
  - Else if full: hold state, hold cnt, no write (stall).
  - Else: write.
    - w_en=1, w_data=req_data[owner], grant[owner]=1.
    - cnt increments.
    - If cnt was BURST_LEN-1, go to IDLE and set ptr = (owner+1) mod NUM_REQ.
- w_en, w_data and grant are combinational from state, owner, req, req_data and full. This makes full act in the same cycle, so the FIFO is never overrun.
- When w_en=0:
  - w_data = 0.
  - grant = 0.
- Producer handshake:
  - A word is consumed on every cycle where grant[i]=1.
  - The producer presents its next word, or drops req, on the following cycle.
  - The producer must not change req_data while req is high and grant[i]=0.
- Wrap-around: ptr and owner wrap from NUM_REQ-1 to 0.
- A requester that drops req mid-burst forfeits the rest of the burst. Priority still rotates past it.
- Simultaneous req drop and full: req drop wins, so the block returns to IDLE.
- If full is held indefinitely, BURST stalls indefinitely. There is no timeout.

## Timing
- Reset values (w_rst synchronous, effective at the next w_clk edge):
  - state=IDLE
  - owner=0
  - ptr=0
  - cnt=0
  - busy=0
  - w_en=0, w_data=0, grant=0
- Reset mid-burst abandons the burst. No w_en is issued on the cycle after the reset edge.
- Latency: req rises before edge N while in IDLE → BURST from edge N → first w_en in cycle N+1 if !full.
- Throughput: one word per cycle inside a burst. There is exactly one IDLE cycle between consecutive bursts.
- busy is registered and equals (state==BURST).

## Structure
- Shared package/include fifo_pkg:
  - State encodings: ST_IDLE=1'b0, ST_BURST=1'b1.
  - Default DATA_SIZE.
- One sub-module, rr_pick: a combinational priority selector.
  - Inputs: req, ptr.
  - Outputs: found, idx.
  - Instantiated once.
- The state register, counters and output mux live in fifo_wr_arbiter.

## Test plan
All scenarios use NUM_REQ=4, BURST_LEN=4, DATA_SIZE=8.
- Single producer: req=4'b0010 held, req1 data 0x10,0x11,… → owner=1, 4 consecutive grant=4'b0010 writes of 0x10..0x13, one IDLE cycle, then a new burst starting with 0x14.
- Round-robin: req=4'b1111 held → burst owners 0,1,2,3,0 in order, 4 writes each, 1 idle cycle between bursts.
- Full stall: full asserted after the 2nd write of a burst for 3 cycles → w_en=0 and grant=0 for those 3 cycles, cnt holds, then writes 3 and 4 complete. Total FIFO writes = 4, no data lost or duplicated.
- Early drop: producer 2 drops req after 1 write while req=4'b0101 → IDLE, ptr=3, next owner=0 (wrap).
- Reset mid-burst: w_rst pulsed after 2 writes → next cycle w_en=0, busy=0, owner=0, ptr=0. Arbitration restarts from producer 0.
- Drop+full same cycle: req[owner]=0 and full=1 together → no write, IDLE next, ptr=owner+1.
